// File: rtl/xmm_read_converter_if.sv
// Handshake bundle for xmm_read_converter: Q15 input channel and 32-bit result channel.
// Flag signals exist only when XMM_READ_FLAGS_EN is defined.
interface xmm_read_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef XMM_READ_FLAGS_EN
  logic        out_inexact;
  logic        out_sat;
`endif

  modport master (
    output in_valid,
    output in_mode,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef XMM_READ_FLAGS_EN
    input  out_inexact,
    input  out_sat,
`endif
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef XMM_READ_FLAGS_EN
    output out_inexact,
    output out_sat,
`endif
    output out_data
  );
endinterface

// File: rtl/xmm_read_converter.sv
// Q15 XMM value -> u32/i32/fp32 word; XMM_READ_FLAGS_EN adds inexact/saturate flags.
// Latency: 1 edge for integer/reserved/zero, NORM shifts + 2 edges for fp32.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module xmm_read_converter #(
  parameter int NORM_STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  xmm_read_converter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam logic [1:0] MODE_U32  = 2'b00;
  localparam logic [1:0] MODE_I32  = 2'b01;
  localparam logic [1:0] MODE_FP32 = 2'b10;

  state_t      state, state_nxt;
  logic [63:0] m_q;
  logic [6:0]  s_q;
  logic        sign_q;
  logic [1:0]  mode_q;
  logic [63:0] in_mag;
  logic [31:0] res_dat;

  // -2^63 wraps to itself, which read as unsigned is exactly 2^63
  assign in_mag       = bus.in_data[63] ? (~bus.in_data + 64'd1) : bus.in_data;
  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)
                 state_nxt = (bus.in_mode != MODE_FP32 || in_mag == 64'd0) ? ROUND : NORM;
      NORM:    if (m_q[63]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coarse shift first, then single steps, so no wide priority encoder is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q    <= '0;
      s_q    <= '0;
      sign_q <= 1'b0;
      mode_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          m_q    <= in_mag;
          s_q    <= '0;
          sign_q <= bus.in_data[63];
          mode_q <= bus.in_mode;
        end
        NORM: if (m_q[63 -: NORM_STEP] == '0) begin
          m_q <= m_q << NORM_STEP;
          s_q <= s_q + 7'(NORM_STEP);
        end else if (!m_q[63]) begin
          m_q <= m_q << 1;
          s_q <= s_q + 7'd1;
        end
        default: ;
      endcase
    end
  end

  logic [48:0] tr_mag;
  logic        grd, sticky, rnd_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_val;

  assign tr_mag   = m_q[63:15];
  assign grd      = m_q[39];
  assign sticky   = |m_q[38:0];
  assign rnd_up   = grd & (sticky | m_q[40]);
  assign mant_rnd = {1'b0, m_q[62:40]} + 24'(rnd_up);
  assign exp_val  = 8'd175 - {1'b0, s_q} + {7'd0, mant_rnd[23]};

`ifdef XMM_READ_FLAGS_EN
  logic frac_nz, res_inexact, res_sat;
  assign frac_nz = |m_q[14:0];
`endif

  always_comb begin
    res_dat = '0;
`ifdef XMM_READ_FLAGS_EN
    res_inexact = 1'b0;
    res_sat     = 1'b0;
`endif
    case (mode_q)
      MODE_U32: begin
`ifdef XMM_READ_FLAGS_EN
        res_inexact = frac_nz;
        res_sat     = sign_q ? (tr_mag != '0) : (tr_mag > 49'hFFFF_FFFF);
`endif
        if (sign_q)                     res_dat = '0;
        else if (tr_mag > 49'hFFFF_FFFF) res_dat = 32'hFFFF_FFFF;
        else                            res_dat = tr_mag[31:0];
      end
      MODE_I32: begin
`ifdef XMM_READ_FLAGS_EN
        res_inexact = frac_nz;
        res_sat     = sign_q ? (tr_mag > 49'h8000_0000) : (tr_mag > 49'h7FFF_FFFF);
`endif
        if (sign_q) begin
          if (tr_mag > 49'h8000_0000) res_dat = 32'h8000_0000;
          else                        res_dat = ~tr_mag[31:0] + 32'd1;
        end else begin
          if (tr_mag > 49'h7FFF_FFFF) res_dat = 32'h7FFF_FFFF;
          else                        res_dat = tr_mag[31:0];
        end
      end
      MODE_FP32: begin
        if (m_q != '0) res_dat = {sign_q, exp_val, mant_rnd[22:0]};
`ifdef XMM_READ_FLAGS_EN
        res_inexact = grd | sticky;
`endif
      end
      default: res_dat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
`ifdef XMM_READ_FLAGS_EN
      bus.out_inexact <= 1'b0;
      bus.out_sat     <= 1'b0;
`endif
    end else if (state == ROUND) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= res_dat;
`ifdef XMM_READ_FLAGS_EN
      bus.out_inexact <= res_inexact;
      bus.out_sat     <= res_sat;
`endif
    end else if (state == DONE && bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xmm_read_converter.sv
// Directed bench for xmm_read_converter: values, latency, backpressure and mid-flight reset.
module tb_xmm_read_converter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  xmm_read_converter_if bus();

  xmm_read_converter #(.NORM_STEP(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [1:0] mode, input logic [63:0] data, input logic rdy);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_data   = data;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mode  = ~mode;
    bus.in_data  = ~data;
  endtask

  task automatic run_conv(input string tag, input logic [1:0] mode, input logic [63:0] data,
                          input logic [31:0] exp_dat, input int exp_lat,
                          input logic exp_ix, input logic exp_sat, input int hold);
    int   lat;
    logic busy_ok;
    logic stable_ok;
    logic [31:0] held;
    lat     = 0;
    busy_ok = 1'b1;
    accept(mode, data, hold == 0);
    while (lat <= 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.in_ready) busy_ok = 1'b0;
      if (bus.out_valid) break;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(bus.out_data), 64'(exp_dat));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
`ifdef XMM_READ_FLAGS_EN
    check({tag, "_inexact"}, 64'(bus.out_inexact), 64'(exp_ix));
    check({tag, "_sat"}, 64'(bus.out_sat), 64'(exp_sat));
`else
    if (exp_ix === 1'bx || exp_sat === 1'bx) $display("note: unknown flag expectation");
`endif
    if (hold > 0) begin
      held      = bus.out_data;
      stable_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!bus.out_valid || bus.in_ready || bus.out_data !== held) stable_ok = 1'b0;
      end
      check({tag, "_hold"}, 64'(stable_ok), 64'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_retire_vld"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_retire_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic stale;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    check("rst_dat", 64'(bus.out_data), 64'd0);
    check("rst_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    run_conv("fp_one",     2'b10, 64'h0000_0000_0000_8000, 32'h3F80_0000,  8, 1'b0, 1'b0, 0);
    run_conv("fp_m2p5",    2'b10, 64'hFFFF_FFFF_FFFE_C000, 32'hC020_0000, 14, 1'b0, 1'b0, 0);
    run_conv("i32_m2p5",   2'b01, 64'hFFFF_FFFF_FFFE_C000, 32'hFFFF_FFFE,  1, 1'b1, 1'b0, 0);
    run_conv("fp_min",     2'b10, 64'h8000_0000_0000_0000, 32'hD780_0000,  2, 1'b0, 1'b0, 0);
    run_conv("fp_lsb",     2'b10, 64'h0000_0000_0000_0001, 32'h3800_0000, 16, 1'b0, 1'b0, 0);
    run_conv("fp_zero",    2'b10, 64'h0000_0000_0000_0000, 32'h0000_0000,  1, 1'b0, 1'b0, 0);
    run_conv("u32_big",    2'b00, 64'h0080_0000_0000_0000, 32'hFFFF_FFFF,  1, 1'b0, 1'b1, 0);
    run_conv("u32_neg",    2'b00, 64'hFFFF_FFFF_FFFF_8000, 32'h0000_0000,  1, 1'b0, 1'b1, 0);
    run_conv("rsvd",       2'b11, 64'h0000_1234_5678_8000, 32'h0000_0000,  1, 1'b0, 1'b0, 0);
    run_conv("i32_negsat", 2'b01, 64'hFFFF_8000_0000_0000, 32'h8000_0000,  1, 1'b0, 1'b1, 0);
    run_conv("i32_min",    2'b01, 64'hFFFF_C000_0000_0000, 32'h8000_0000,  1, 1'b0, 1'b0, 0);
    run_conv("i32_pos",    2'b01, 64'h0000_0000_0001_2345, 32'h0000_0002,  1, 1'b1, 1'b0, 0);
    run_conv("fp_tie_dn",  2'b10, 64'h4000_0040_0000_0000, 32'h5700_0000,  3, 1'b1, 1'b0, 0);
    run_conv("fp_tie_up",  2'b10, 64'h4000_00C0_0000_0000, 32'h5700_0002,  3, 1'b1, 1'b0, 0);
    run_conv("fp_carry",   2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 32'h5780_0000,  3, 1'b1, 1'b0, 0);
    run_conv("bp_fp_one",  2'b10, 64'h0000_0000_0000_8000, 32'h3F80_0000,  8, 1'b0, 1'b0, 5);

    // Reset while the normalizer is still shifting
    accept(2'b10, 64'h0000_0000_0000_0001, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_vld", 64'(bus.out_valid), 64'd0);
    check("midrst_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale = 1'b1;
    end
    check("midrst_stale", 64'(stale), 64'd0);
    run_conv("post_rst",   2'b10, 64'hFFFF_FFFF_FFFE_C000, 32'hC020_0000, 14, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/xmm_read_converter.md
Name: xmm_read_converter

Overview:
- Read-side counterpart of the XMM write path: converts a 64-bit Q15 XMM register value back to a 32-bit u32, i32 or fp32 word.
- Feeds ALU operands and memory store data.
- Multi-cycle, with a valid/ready handshake on input and output. The fp32 path uses an iterative normalizer instead of a 64-bit priority encoder.

Parameters:
- NORM_STEP, 8, coarse left-shift distance per NORM cycle; must be a power of two between 2 and 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_mode valid
- in_ready  output  1  block idle and able to accept
- in_mode  input  2  2'b00 u32, 2'b01 i32, 2'b10 fp32, 2'b11 reserved
- in_data  input  64  XMM value: two's-complement Q15, bits [14:0] fractional
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  converted result

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; out_valid=0, out_data=0, in_ready=1.
  - Any in-flight conversion is dropped; no output is produced for it.
- States:
  - IDLE: in_ready=1 only here. On in_valid, latch in_mode and sign; latch magnitude m=|in_data| as a 64-bit unsigned value (-2^63 gives m=2^63); clear shift count s.
  - From IDLE: go to ROUND if mode!=fp32 or m==0; otherwise go to NORM.
  - NORM, one of three actions per cycle:
    - m[63:64-NORM_STEP]==0: m<<=NORM_STEP, s+=NORM_STEP.
    - else if m[63]==0: m<<=1, s+=1.
    - else (m[63]==1): go to ROUND.
  - ROUND: compute the result, register it to out_data, set out_valid=1, go to DONE.
  - DONE: hold out_data and out_valid stable until out_ready. On the out_ready cycle, clear out_valid and go to IDLE.
  - No accept in the same cycle as output retire; the next accept is possible one cycle later.
- fp32 rounding:
  - sign = in_data[63]; exponent = 175-s, always in range 112..175, so always normal and never inf.
  - Mantissa = m[62:40], guard = m[39], sticky = |m[38:0].
  - Round to nearest even. On mantissa carry-out: mantissa=0, exponent+1.
  - m==0 gives 32'h0000_0000 (+0).
- i32:
  - Truncate toward zero: take in_data>>>15, then add 1 if negative and in_data[14:0]!=0.
  - Saturate to [32'h8000_0000, 32'h7FFF_FFFF].
- u32:
  - Same truncation as i32.
  - Negative results give 0; results above 2^32-1 give 32'hFFFF_FFFF.
- Reserved mode 2'b11: result 32'h0000_0000, same latency as integer modes.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - Integer, reserved and zero inputs: 1 edge.
  - fp32: (number of NORM shifts) + 2 edges.
  - fp32 with NORM_STEP=8: 2 edges minimum (m[63] already set), 16 edges maximum (m==1).
- in_data/in_mode are ignored except in the accept cycle. Changes to out_ready while out_valid=0 have no effect.

Optional Feature:
- Macro: XMM_READ_FLAGS_EN.
- Defined: adds output ports out_inexact (1) and out_sat (1). Both are valid with out_valid, held through DONE, and reset to 0.
  - out_inexact: any discarded fraction bits (integer modes) or guard|sticky set (fp32).
  - out_sat: integer clamp applied.
- Undefined: neither port exists. Data behaviour and latency are unchanged.

Test Plan:
- fp32, in_data=64'h0000_0000_0000_8000 (1.0), out_ready=1 → out_data=32'h3F80_0000; out_valid rises at edge 8 after accept; in_ready low until return to IDLE.
- fp32, in_data=64'hFFFF_FFFF_FFFE_C000 (-2.5) → 32'hC020_0000. i32 with the same input → 32'hFFFF_FFFE (-2) at edge 1, inexact=1.
- fp32 bounds: in_data=64'h8000_0000_0000_0000 → 32'hD780_0000 at edge 2. in_data=64'h1 → 32'h3800_0000 at edge 16. in_data=0 → 32'h0 at edge 1.
- u32 saturation: in_data=64'h0080_0000_0000_0000 → 32'hFFFF_FFFF, sat=1. u32 with in_data=64'hFFFF_FFFF_FFFF_8000 (-1.0) → 32'h0, sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data/out_valid stable and in_ready=0; raise out_ready → out_valid clears, in_ready=1 the next cycle.
- Reset mid-NORM: assert reset 3 cycles after accepting fp32 input 64'h1 → out_valid=0, in_ready=1 immediately; no stale output after release. The next conversion is correct.
